// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - icache tag/data RAM write controller: reset invalidation sweep and line refill
module icache_refill #(
   parameter int TAG_W   = 20,
   parameter int INDEX_W = 7,
   parameter int WORD_W  = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       miss,
   input  logic [31:0]                miss_addr,
   output logic                       refill_busy,
   output logic                       refill_done,
   output logic                       init_done,
   output logic                       refill_err,
   output logic                       tag_en,
   output logic [3:0]                 tag_wen,
   output logic [INDEX_W-1:0]         tag_addr,
   output logic [TAG_W:0]             tag_wdata,
   output logic                       data_en,
   output logic [3:0]                 data_wen,
   output logic [INDEX_W+WORD_W-1:0]  data_addr,
   output logic [31:0]                data_wdata,
   output logic                       rd_req,
   output logic [31:0]                rd_addr,
   input  logic                       rd_addr_ok,
   input  logic                       rd_data_valid,
   input  logic [31:0]                rd_data,
   input  logic                       rd_last
);

   // Line address = tag + index; the low bits select the byte within a line.
   localparam int LINE_W = TAG_W + INDEX_W;
   localparam int OFF_W  = 32 - LINE_W;

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_REQ,
      S_RECV,
      S_TAGW,
      S_DONE
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic [INDEX_W-1:0]  init_cnt;
   logic [WORD_W-1:0]   word_cnt;
   logic [LINE_W-1:0]   line;
   logic                init_last;
   logic                word_last;
   logic                unused_addr_bits;

   assign init_last = (init_cnt == {INDEX_W{1'b1}});
   assign word_last = (word_cnt == {WORD_W{1'b1}});

   // Byte offset of the miss address does not matter for a whole-line fetch.
   assign unused_addr_bits = ^miss_addr[OFF_W-1:0];

   // State register; reset always restarts the invalidation sweep.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_INIT;
      end else begin
         state <= state_nx;
      end
   end

   // Sweep and beat counters, latched miss line, and the sticky status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         init_cnt   <= '0;
         word_cnt   <= '0;
         line       <= '0;
         init_done  <= 1'b0;
         refill_err <= 1'b0;
      end else begin
         case (state)
            S_INIT: begin
               init_cnt <= init_cnt + INDEX_W'(1);
               if (init_last) begin
                  init_done <= 1'b1;
               end
            end
            S_IDLE: begin
               if (miss) begin
                  line <= miss_addr[31 -: LINE_W];
               end
            end
            S_REQ: begin
               if (rd_addr_ok) begin
                  word_cnt <= '0;
               end
            end
            S_RECV: begin
               if (rd_data_valid) begin
                  word_cnt <= word_cnt + WORD_W'(1);
                  // rd_last is only a consistency check; the beat count ends the line.
                  if (rd_last != word_last) begin
                     refill_err <= 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Next state and RAM/memory strobes; everything idles while reset is held.
   always_comb begin
      state_nx    = state;
      refill_busy = 1'b1;
      refill_done = 1'b0;
      tag_en      = 1'b0;
      tag_wen     = 4'h0;
      tag_addr    = '0;
      tag_wdata   = '0;
      data_en     = 1'b0;
      data_wen    = 4'h0;
      data_addr   = '0;
      data_wdata  = '0;
      rd_req      = 1'b0;
      rd_addr     = '0;
      if (!rst) begin
         case (state)
            S_INIT: begin
               tag_en   = 1'b1;
               tag_wen  = 4'hF;
               tag_addr = init_cnt;
               if (init_last) begin
                  state_nx = S_IDLE;
               end
            end
            S_IDLE: begin
               refill_busy = 1'b0;
               if (miss) begin
                  state_nx = S_REQ;
               end
            end
            S_REQ: begin
               rd_req  = 1'b1;
               rd_addr = {line, {OFF_W{1'b0}}};
               if (rd_addr_ok) begin
                  state_nx = S_RECV;
               end
            end
            S_RECV: begin
               if (rd_data_valid) begin
                  data_en    = 1'b1;
                  data_wen   = 4'hF;
                  data_addr  = {line[INDEX_W-1:0], word_cnt};
                  data_wdata = rd_data;
                  if (word_last) begin
                     state_nx = S_TAGW;
                  end
               end
            end
            S_TAGW: begin
               // Tag goes valid only after all data words are in place.
               tag_en    = 1'b1;
               tag_wen   = 4'hF;
               tag_addr  = line[INDEX_W-1:0];
               tag_wdata = {1'b1, line[LINE_W-1 -: TAG_W]};
               state_nx  = S_DONE;
            end
            S_DONE: begin
               refill_done = 1'b1;
               state_nx    = S_IDLE;
            end
            default: begin
               state_nx = S_INIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_icache_refill.sv
// tb/tb_icache_refill.sv - directed self-checking bench for icache_refill
module tb_icache_refill;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        miss = 1'b0;
   logic [31:0] miss_addr = '0;
   logic        refill_busy;
   logic        refill_done;
   logic        init_done;
   logic        refill_err;
   logic        tag_en;
   logic [3:0]  tag_wen;
   logic [6:0]  tag_addr;
   logic [20:0] tag_wdata;
   logic        data_en;
   logic [3:0]  data_wen;
   logic [9:0]  data_addr;
   logic [31:0] data_wdata;
   logic        rd_req;
   logic [31:0] rd_addr;
   logic        rd_addr_ok = 1'b0;
   logic        rd_data_valid = 1'b0;
   logic [31:0] rd_data = '0;
   logic        rd_last = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_pulses = 0;

   icache_refill dut (
      .clk           (clk),
      .rst           (rst),
      .miss          (miss),
      .miss_addr     (miss_addr),
      .refill_busy   (refill_busy),
      .refill_done   (refill_done),
      .init_done     (init_done),
      .refill_err    (refill_err),
      .tag_en        (tag_en),
      .tag_wen       (tag_wen),
      .tag_addr      (tag_addr),
      .tag_wdata     (tag_wdata),
      .data_en       (data_en),
      .data_wen      (data_wen),
      .data_addr     (data_addr),
      .data_wdata    (data_wdata),
      .rd_req        (rd_req),
      .rd_addr       (rd_addr),
      .rd_addr_ok    (rd_addr_ok),
      .rd_data_valid (rd_data_valid),
      .rd_data       (rd_data),
      .rd_last       (rd_last)
   );

   always #5 clk = ~clk;

   // Cycle counter used for latency measurement.
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] beat_word(input logic [31:0] a, input int i);
      return {a[31:5], 5'b0} ^ (32'h0101_0101 * (i + 1));
   endfunction

   // Tag and data RAMs must never be written together.
   always @(negedge clk) begin
      if (tag_en || data_en) check("no_overlap", {63'b0, tag_en & data_en}, 64'd0);
   end

   // Count refill_done pulses across the whole run.
   always @(negedge clk) begin
      if (refill_done) done_pulses++;
   end

   // Called at posedge+1 with rst high; releases reset and checks the 128-set sweep.
   task automatic init_sweep(input bit stale);
      rst = 1'b0;
      miss = stale;
      miss_addr = 32'hCAFE_0000;
      rd_data_valid = stale;
      rd_data = 32'hDEAD_0000;
      for (int i = 0; i < 128; i++) begin
         @(negedge clk);
         check("init_tag_en", tag_en, 1);
         check("init_tag_wen", tag_wen, 4'hF);
         check("init_tag_addr", tag_addr, i);
         check("init_tag_wdata", tag_wdata, 0);
         check("init_busy", refill_busy, 1);
         check("init_no_data", data_en, 0);
         check("init_done_low", init_done, 0);
         @(posedge clk); #1;
      end
      miss = 1'b0;
      rd_data_valid = 1'b0;
      @(negedge clk);
      check("init_done_high", init_done, 1);
      check("idle_busy", refill_busy, 0);
      check("idle_tag_en", tag_en, 0);
      check("idle_rd_req", rd_req, 0);
      @(posedge clk); #1;
   endtask

   // Called at posedge+1 in IDLE; returns at posedge+1 of the cycle after DONE
   // (or right after asserting reset when abort_at >= 0).
   task automatic run_refill(input logic [31:0] a, input logic [31:0] exp_rd,
                             input logic [6:0] exp_idx, input logic [19:0] exp_tag,
                             input int dly, input int gap, input int last_at,
                             input bit hold, input bit chk_lat, input int abort_at);
      int reqc, beat, gapc, writes, tags, n, c0, first_req, tag_cyc, done_cyc;
      bit acked, done;
      reqc = 0; beat = 0; gapc = 0; writes = 0; tags = 0; n = 0;
      first_req = -1; tag_cyc = -1; done_cyc = -1; acked = 0; done = 0;
      miss = 1'b1;
      miss_addr = a;
      c0 = cyc;
      while (!done && n < 400) begin
         rd_addr_ok = 1'b0;
         rd_data_valid = 1'b0;
         rd_last = 1'b0;
         rd_data = '0;
         if (abort_at >= 0 && beat == abort_at) begin
            rst = 1'b1;
            miss = 1'b0;
            rd_data_valid = 1'b1;
            rd_data = beat_word(a, beat);
            check("abort_writes", writes, abort_at);
            return;
         end
         if (!acked) begin
            if (rd_req) begin
               reqc++;
               if (reqc > dly) rd_addr_ok = 1'b1;
            end
         end else if (beat < 8) begin
            if (gapc == 0) begin
               rd_data_valid = 1'b1;
               rd_data = beat_word(a, beat);
               rd_last = (beat == last_at);
               beat++;
               gapc = gap;
            end else begin
               gapc--;
            end
         end
         @(negedge clk);
         if (rd_req) begin
            if (first_req < 0) first_req = cyc - c0;
            check("rd_addr", rd_addr, exp_rd);
         end
         if (data_en) begin
            check("data_addr", data_addr, {exp_idx, writes[2:0]});
            check("data_wdata", data_wdata, beat_word(a, writes));
            check("data_wen", data_wen, 4'hF);
            writes++;
         end
         if (tag_en) begin
            tag_cyc = cyc - c0;
            tags++;
            check("tag_after_line", writes, 8);
            check("tag_addr", tag_addr, exp_idx);
            check("tag_wdata", tag_wdata, {1'b1, exp_tag});
            check("tag_wen", tag_wen, 4'hF);
         end
         if (refill_done) begin
            done = 1;
            done_cyc = cyc - c0;
         end
         if (rd_addr_ok) acked = 1;
         @(posedge clk); #1;
         n++;
      end
      rd_addr_ok = 1'b0;
      rd_data_valid = 1'b0;
      rd_last = 1'b0;
      miss = hold;
      check("refill_done_seen", done, 1);
      check("data_writes", writes, 8);
      check("tag_writes", tags, 1);
      check("req_latency", first_req, 1);
      if (dly > 0) check("req_cycles", reqc, dly + 1);
      if (chk_lat) begin
         check("tag_latency", tag_cyc, 10);
         check("done_latency", done_cyc, 11);
      end
   endtask

   task automatic idle_check(input string tag, input logic exp_err);
      @(negedge clk);
      check(tag, refill_err, exp_err);
      check("idle_not_busy", refill_busy, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tag_en", tag_en, 0);
      check("rst_tag_wen", tag_wen, 0);
      check("rst_data_en", data_en, 0);
      check("rst_data_wen", data_wen, 0);
      check("rst_rd_req", rd_req, 0);
      check("rst_refill_done", refill_done, 0);
      check("rst_busy", refill_busy, 1);
      check("rst_init_done", init_done, 0);
      check("rst_refill_err", refill_err, 0);
      @(posedge clk); #1;
      init_sweep(1'b0);

      // Minimum-latency refill
      run_refill(32'h1FC0_0A64, 32'h1FC0_0A60, 7'h53, 20'h1FC00, 0, 0, 7, 1'b0, 1'b1, -1);
      idle_check("err_after_t2", 1'b0);

      // Delayed ack and gapped beats
      run_refill(32'h0000_1234, 32'h0000_1220, 7'h11, 20'h00001, 5, 2, 7, 1'b0, 1'b0, -1);
      idle_check("err_after_t3", 1'b0);

      // Early rd_last sets sticky error but the line still completes
      run_refill(32'hDEAD_BEEF, 32'hDEAD_BEE0, 7'h77, 20'hDEADB, 0, 0, 5, 1'b0, 1'b0, -1);
      idle_check("err_after_t4", 1'b1);
      idle_check("err_sticky", 1'b1);

      // Reset in the middle of a refill while beats keep arriving
      run_refill(32'h8000_0FE0, 32'h8000_0FE0, 7'h7F, 20'h80000, 0, 0, 7, 1'b0, 1'b0, 4);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_no_data", data_en, 0);
         check("abort_no_tag", tag_en, 0);
         check("abort_err_clr", refill_err, 0);
         check("abort_busy", refill_busy, 1);
         check("abort_init_done", init_done, 0);
         @(posedge clk); #1;
         rd_data_valid = 1'b1;
      end
      init_sweep(1'b1);
      run_refill(32'h0000_0020, 32'h0000_0020, 7'h01, 20'h00000, 0, 1, 7, 1'b0, 1'b0, -1);

      // Miss held through DONE: the next line starts from IDLE
      run_refill(32'h1234_5678, 32'h1234_5660, 7'h33, 20'h12345, 0, 0, 7, 1'b1, 1'b1, -1);
      run_refill(32'hFFFF_FFFC, 32'hFFFF_FFE0, 7'h7F, 20'hFFFFF, 0, 0, 7, 1'b0, 1'b1, -1);
      idle_check("err_after_t6", 1'b0);
      idle_check("idle_settle", 1'b0);
      check("done_pulses", done_pulses, 6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
